// File: rtl/uart_rx_deser_chk.sv
// UART RX deserialiser/checker: follows frame position on each bit strobe,
// shifts data LSB-first, checks start/parity/stop and emits one-cycle result pulses.
module uart_rx_deser_chk #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  CLK_DES,
  input  logic                  RST_DES,
  input  logic [4:0]            Prescale_DES,
  input  logic [3:0]            edge_cnt_DES,
  input  logic                  sampled_bit_DES,
  input  logic                  frame_en_DES,
  input  logic                  PAR_EN_DES,
  input  logic                  PAR_TYP_DES,
  output logic [DATA_WIDTH-1:0] P_DATA_DES,
  output logic                  data_valid_DES,
  output logic                  par_err_DES,
  output logic                  stp_err_DES,
  output logic                  strt_glitch_DES,
  output logic                  busy_DES
);

  localparam int unsigned IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DRAIN
  } state_t;

  state_t                state;
  logic                  ps8_q;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  perr_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic [IW-1:0]         idx;
  logic [3:0]            last_edge;
  logic                  strb;
  logic                  exp_par;
  logic                  in_frame;

  always_comb begin
    last_edge = ps8_q ? 4'd7 : 4'd15;
    strb      = frame_en_DES && (edge_cnt_DES == last_edge);
    exp_par   = par_typ_q ? ~(^shreg) : (^shreg);
    in_frame  = (state == START) || (state == DATA) ||
                (state == PARITY) || (state == STOP);
  end

  always_ff @(posedge CLK_DES or negedge RST_DES) begin
    if (!RST_DES) begin
      state           <= IDLE;
      ps8_q           <= 1'b0;
      par_en_q        <= 1'b0;
      par_typ_q       <= 1'b0;
      perr_q          <= 1'b0;
      shreg           <= '0;
      idx             <= '0;
      P_DATA_DES      <= '0;
      data_valid_DES  <= 1'b0;
      par_err_DES     <= 1'b0;
      stp_err_DES     <= 1'b0;
      strt_glitch_DES <= 1'b0;
      busy_DES        <= 1'b0;
    end else begin
      data_valid_DES  <= 1'b0;
      par_err_DES     <= 1'b0;
      stp_err_DES     <= 1'b0;
      strt_glitch_DES <= 1'b0;

      // Dropping frame_en aborts silently and outranks a coincident strobe.
      if (in_frame && !frame_en_DES) begin
        state    <= IDLE;
        busy_DES <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (frame_en_DES) begin
              state     <= START;
              busy_DES  <= 1'b1;
              ps8_q     <= (Prescale_DES == 5'd8);
              par_en_q  <= PAR_EN_DES;
              par_typ_q <= PAR_TYP_DES;
              idx       <= '0;
              perr_q    <= 1'b0;
            end
          end
          START: begin
            if (strb) begin
              if (sampled_bit_DES) begin
                strt_glitch_DES <= 1'b1;
                state           <= DRAIN;
              end else begin
                idx   <= '0;
                state <= DATA;
              end
            end
          end
          DATA: begin
            if (strb) begin
              shreg <= {sampled_bit_DES, shreg[DATA_WIDTH-1:1]};
              idx   <= idx + 1'b1;
              if (idx == LAST_IDX) begin
                state <= par_en_q ? PARITY : STOP;
              end
            end
          end
          PARITY: begin
            if (strb) begin
              perr_q <= (sampled_bit_DES != exp_par);
              state  <= STOP;
            end
          end
          STOP: begin
            if (strb) begin
              par_err_DES <= perr_q;
              stp_err_DES <= ~sampled_bit_DES;
              if (!perr_q && sampled_bit_DES) begin
                P_DATA_DES     <= shreg;
                data_valid_DES <= 1'b1;
              end
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (!frame_en_DES) begin
              state    <= IDLE;
              busy_DES <= 1'b0;
            end
          end
          default: begin
            state    <= IDLE;
            busy_DES <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_deser_chk.sv
// Directed bench for uart_rx_deser_chk: drives per-bit edge counts and sampled
// bits frame by frame and checks pulses, data and busy against hand values.
module tb_uart_rx_deser_chk;

  logic       CLK_DES;
  logic       RST_DES;
  logic [4:0] Prescale_DES;
  logic [3:0] edge_cnt_DES;
  logic       sampled_bit_DES;
  logic       frame_en_DES;
  logic       PAR_EN_DES;
  logic       PAR_TYP_DES;
  logic [7:0] P_DATA_DES;
  logic       data_valid_DES;
  logic       par_err_DES;
  logic       stp_err_DES;
  logic       strt_glitch_DES;
  logic       busy_DES;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  int unsigned cnt_v = 0;
  int unsigned cnt_p = 0;
  int unsigned cnt_s = 0;
  int unsigned cnt_g = 0;

  uart_rx_deser_chk #(.DATA_WIDTH(8)) dut (
    .CLK_DES         (CLK_DES),
    .RST_DES         (RST_DES),
    .Prescale_DES    (Prescale_DES),
    .edge_cnt_DES    (edge_cnt_DES),
    .sampled_bit_DES (sampled_bit_DES),
    .frame_en_DES    (frame_en_DES),
    .PAR_EN_DES      (PAR_EN_DES),
    .PAR_TYP_DES     (PAR_TYP_DES),
    .P_DATA_DES      (P_DATA_DES),
    .data_valid_DES  (data_valid_DES),
    .par_err_DES     (par_err_DES),
    .stp_err_DES     (stp_err_DES),
    .strt_glitch_DES (strt_glitch_DES),
    .busy_DES        (busy_DES)
  );

  initial CLK_DES = 1'b0;
  always #5 CLK_DES = ~CLK_DES;

  always @(negedge CLK_DES) begin
    if (data_valid_DES === 1'b1) cnt_v <= cnt_v + 1;
    if (par_err_DES === 1'b1) cnt_p <= cnt_p + 1;
    if (stp_err_DES === 1'b1) cnt_s <= cnt_s + 1;
    if (strt_glitch_DES === 1'b1) cnt_g <= cnt_g + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send_bit(input logic b, input int unsigned ps);
    for (int unsigned e = 0; e < ps; e++) begin
      @(negedge CLK_DES);
      edge_cnt_DES    = 4'(e);
      sampled_bit_DES = b;
    end
  endtask

  task automatic idle_gap();
    frame_en_DES    = 1'b0;
    edge_cnt_DES    = 4'd0;
    sampled_bit_DES = 1'b1;
    repeat (3) @(negedge CLK_DES);
  endtask

  // Config inputs are disturbed after the start bit; the frame must still use
  // the values presented at frame start.
  task automatic run_frame(input string nm, input logic [7:0] d, input logic pen,
                           input logic ptyp, input logic pbit, input logic sbit,
                           input int unsigned ps, input logic ev, input logic ep,
                           input logic es);
    Prescale_DES = 5'(ps);
    PAR_EN_DES   = pen;
    PAR_TYP_DES  = ptyp;
    frame_en_DES = 1'b1;
    send_bit(1'b0, ps);
    Prescale_DES = (ps == 8) ? 5'd16 : 5'd8;
    PAR_EN_DES   = ~pen;
    PAR_TYP_DES  = ~ptyp;
    for (int i = 0; i < 8; i++) send_bit(d[i], ps);
    if (pen) send_bit(pbit, ps);
    send_bit(sbit, ps);
    @(negedge CLK_DES);
    n_cmp++;
    if (data_valid_DES !== ev) begin
      n_bad++;
      $display("FAIL %s valid_cycle: got %b expected %b", nm, data_valid_DES, ev);
    end
    n_cmp++;
    if (par_err_DES !== ep) begin
      n_bad++;
      $display("FAIL %s par_err_cycle: got %b expected %b", nm, par_err_DES, ep);
    end
    n_cmp++;
    if (stp_err_DES !== es) begin
      n_bad++;
      $display("FAIL %s stp_err_cycle: got %b expected %b", nm, stp_err_DES, es);
    end
    Prescale_DES = 5'(ps);
    PAR_EN_DES   = pen;
    PAR_TYP_DES  = ptyp;
    idle_gap();
  endtask

  task automatic check_counts(input string nm, input int unsigned v0, input int unsigned p0,
                              input int unsigned s0, input int unsigned g0,
                              input int unsigned ev, input int unsigned ep,
                              input int unsigned es, input int unsigned eg,
                              input logic [7:0] edata);
    n_cmp++;
    if (cnt_v - v0 !== ev) begin
      n_bad++;
      $display("FAIL %s valid_count: got %0d expected %0d", nm, cnt_v - v0, ev);
    end
    n_cmp++;
    if (cnt_p - p0 !== ep) begin
      n_bad++;
      $display("FAIL %s par_err_count: got %0d expected %0d", nm, cnt_p - p0, ep);
    end
    n_cmp++;
    if (cnt_s - s0 !== es) begin
      n_bad++;
      $display("FAIL %s stp_err_count: got %0d expected %0d", nm, cnt_s - s0, es);
    end
    n_cmp++;
    if (cnt_g - g0 !== eg) begin
      n_bad++;
      $display("FAIL %s glitch_count: got %0d expected %0d", nm, cnt_g - g0, eg);
    end
    n_cmp++;
    if (P_DATA_DES !== edata) begin
      n_bad++;
      $display("FAIL %s p_data: got %h expected %h", nm, P_DATA_DES, edata);
    end
    n_cmp++;
    if (busy_DES !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_after: got %b expected 0", nm, busy_DES);
    end
  endtask

  task automatic test_reset();
    RST_DES         = 1'b0;
    Prescale_DES    = 5'd16;
    edge_cnt_DES    = 4'd0;
    sampled_bit_DES = 1'b1;
    frame_en_DES    = 1'b0;
    PAR_EN_DES      = 1'b0;
    PAR_TYP_DES     = 1'b0;
    repeat (3) @(negedge CLK_DES);
    RST_DES = 1'b1;
    repeat (2) @(negedge CLK_DES);
    n_cmp++;
    if ({P_DATA_DES, data_valid_DES, par_err_DES, stp_err_DES, strt_glitch_DES, busy_DES} !== 13'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h/%b%b%b%b%b expected 00/00000", P_DATA_DES,
               data_valid_DES, par_err_DES, stp_err_DES, strt_glitch_DES, busy_DES);
    end
  endtask

  task automatic test_basic();
    int unsigned v0 = cnt_v, p0 = cnt_p, s0 = cnt_s, g0 = cnt_g;
    run_frame("basic_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0);
    check_counts("basic_a5", v0, p0, s0, g0, 1, 0, 0, 0, 8'hA5);
  endtask

  task automatic test_parity();
    int unsigned v0 = cnt_v, p0 = cnt_p, s0 = cnt_s, g0 = cnt_g;
    run_frame("even_3c_ok", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0);
    check_counts("even_3c_ok", v0, p0, s0, g0, 1, 0, 0, 0, 8'h3C);
    v0 = cnt_v; p0 = cnt_p; s0 = cnt_s; g0 = cnt_g;
    run_frame("even_3c_bad", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b1, 1'b0);
    check_counts("even_3c_bad", v0, p0, s0, g0, 0, 1, 0, 0, 8'h3C);
  endtask

  task automatic test_glitch();
    int unsigned v0 = cnt_v, p0 = cnt_p, s0 = cnt_s, g0 = cnt_g;
    Prescale_DES = 5'd16;
    PAR_EN_DES   = 1'b0;
    frame_en_DES = 1'b1;
    send_bit(1'b1, 16);
    @(negedge CLK_DES);
    n_cmp++;
    if (strt_glitch_DES !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_pulse: got %b expected 1", strt_glitch_DES);
    end
    for (int i = 0; i < 8; i++) send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    @(negedge CLK_DES);
    n_cmp++;
    if (busy_DES !== 1'b1) begin
      n_bad++;
      $display("FAIL glitch_busy_held: got %b expected 1", busy_DES);
    end
    idle_gap();
    check_counts("glitch", v0, p0, s0, g0, 0, 0, 0, 1, 8'h3C);
  endtask

  task automatic test_stop_err();
    int unsigned v0 = cnt_v, p0 = cnt_p, s0 = cnt_s, g0 = cnt_g;
    run_frame("stop0_55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 16, 1'b0, 1'b0, 1'b1);
    check_counts("stop0_55", v0, p0, s0, g0, 0, 0, 1, 0, 8'h3C);
    v0 = cnt_v; p0 = cnt_p; s0 = cnt_s; g0 = cnt_g;
    run_frame("stop0_par_55", 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 16, 1'b0, 1'b1, 1'b1);
    check_counts("stop0_par_55", v0, p0, s0, g0, 0, 1, 1, 0, 8'h3C);
  endtask

  task automatic test_prescale8_abort();
    int unsigned v0 = cnt_v, p0 = cnt_p, s0 = cnt_s, g0 = cnt_g;
    run_frame("odd8_ff", 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8, 1'b1, 1'b0, 1'b0);
    check_counts("odd8_ff", v0, p0, s0, g0, 1, 0, 0, 0, 8'hFF);
    v0 = cnt_v; p0 = cnt_p; s0 = cnt_s; g0 = cnt_g;
    Prescale_DES = 5'd8;
    frame_en_DES = 1'b1;
    send_bit(1'b0, 8);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 8);
    @(negedge CLK_DES);
    frame_en_DES = 1'b0;
    @(negedge CLK_DES);
    n_cmp++;
    if (busy_DES !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_busy: got %b expected 0", busy_DES);
    end
    idle_gap();
    check_counts("abort", v0, p0, s0, g0, 0, 0, 0, 0, 8'hFF);
  endtask

  task automatic test_reset_mid();
    int unsigned v0, p0, s0, g0;
    Prescale_DES = 5'd16;
    PAR_EN_DES   = 1'b0;
    frame_en_DES = 1'b1;
    send_bit(1'b0, 16);
    send_bit(1'b1, 16);
    send_bit(1'b0, 16);
    @(negedge CLK_DES);
    #2 RST_DES = 1'b0;
    #1;
    n_cmp++;
    if (P_DATA_DES !== 8'h00 || busy_DES !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: got p_data %h busy %b expected 00 0", P_DATA_DES, busy_DES);
    end
    frame_en_DES = 1'b0;
    @(negedge CLK_DES);
    RST_DES = 1'b1;
    idle_gap();
    v0 = cnt_v; p0 = cnt_p; s0 = cnt_s; g0 = cnt_g;
    run_frame("post_rst_81", 8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0, 1'b0);
    check_counts("post_rst_81", v0, p0, s0, g0, 1, 0, 0, 0, 8'h81);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_stop_err();
    test_prescale8_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
